// File: rtl/my_pe_pkg.sv
// Shared constants, pipeline-stage type and the width-generic saturating adder
// for the my_pe_vec dot-product engine.
package my_pe_pkg;

    localparam int DEF_DATA_W = 16;
    localparam int DEF_ACC_W  = 40;
    localparam int DEF_DEPTH  = 16;
    localparam int DEF_PIPE   = 2;

    // Widest accumulator sat_add can handle; operands are sign-extended to this.
    localparam int SAT_MAX_W  = 128;

    typedef struct packed {
        logic valid;
        logic last;
    } stage_t;

    typedef struct packed {
        logic                 sat;
        logic [SAT_MAX_W-1:0] sum;
    } sat_res_t;

    // Adds two w-bit signed values (already sign-extended) and clamps to w-bit range.
    function automatic sat_res_t sat_add(
        input logic signed [SAT_MAX_W-1:0] a,
        input logic signed [SAT_MAX_W-1:0] b,
        input int                          w
    );
        logic signed [SAT_MAX_W-1:0] s;
        logic signed [SAT_MAX_W-1:0] hi;
        logic signed [SAT_MAX_W-1:0] lo;
        sat_res_t                    r;
        s  = a + b;
        hi = (SAT_MAX_W'(1) << (w - 1)) - SAT_MAX_W'(1);
        lo = ~hi;
        r.sat = (s > hi) || (s < lo);
        if (s > hi) begin
            r.sum = hi;
        end else if (s < lo) begin
            r.sum = lo;
        end else begin
            r.sum = s;
        end
        return r;
    endfunction

endpackage

// File: rtl/my_pe_buf.sv
// Coefficient buffer: DEPTH x DATA_W simple dual-port RAM, synchronous read,
// read-before-write on an address collision.
module my_pe_buf
    import my_pe_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int DEPTH  = DEF_DEPTH,
    parameter int ADDR_W = $clog2(DEF_DEPTH)
) (
    input  logic              i_clk,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic [ADDR_W-1:0] i_raddr,
    output logic [DATA_W-1:0] o_rdata
);

    // NOTE: storage has no reset so it maps onto block/distributed RAM.
    logic [DATA_W-1:0] r_mem [DEPTH];

    // NOTE: non-blocking write and read in one block give read-before-write.
    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
        o_rdata <= r_mem[i_raddr];
    end

endmodule

// File: rtl/my_pe_vec.sv
// Vector PE: coefficient buffer plus pipelined signed MAC producing one dot
// product per last-framed vector. Define MY_PE_SAT_EN for saturating accumulate.
module my_pe_vec
    import my_pe_pkg::*;
#(
    parameter  int DATA_W = DEF_DATA_W,
    parameter  int ACC_W  = DEF_ACC_W,
    parameter  int DEPTH  = DEF_DEPTH,
    parameter  int PIPE   = DEF_PIPE,
    localparam int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic              aclk,
    input  logic              areset,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] din,
    input  logic              valid,
    input  logic [DATA_W-1:0] ain,
    input  logic              last,
    output logic              dvalid,
    output logic [ACC_W-1:0]  dout,
    output logic              busy,
    output logic              ovf
);

    localparam int PROD_W = 2 * DATA_W;

    generate
        if (ACC_W < PROD_W) begin : g_bad_acc_w
            $error("my_pe_vec: ACC_W must be >= 2*DATA_W");
        end
        if (PIPE < 1) begin : g_bad_pipe
            $error("my_pe_vec: PIPE must be >= 1");
        end
    endgenerate

    logic signed [DATA_W-1:0] w_rdata;
    stage_t                   r_s0;
    logic signed [DATA_W-1:0] r_s0_ain;
    stage_t                   r_pv   [PIPE];
    logic signed [PROD_W-1:0] r_prod [PIPE];
    logic signed [PROD_W-1:0] w_prod;
    logic signed [ACC_W-1:0]  w_prod_ext;
    logic signed [ACC_W-1:0]  w_sum;
    logic signed [ACC_W-1:0]  r_acc;
    logic signed [ACC_W-1:0]  r_res;
    logic                     r_pending;
    logic                     r_res_vld;
    logic                     r_dvalid;
    logic [ACC_W-1:0]         r_dout;
    logic                     w_busy;

    my_pe_buf #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_buf (
        .i_clk   (aclk),
        .i_we    (we),
        .i_waddr (addr),
        .i_wdata (din),
        .i_raddr (addr),
        .o_rdata (w_rdata)
    );

    // S0: operand register alongside the synchronous buffer read.
    always_ff @(posedge aclk) begin
        if (areset) begin
            r_s0 <= '0;
        end else begin
            r_s0.valid <= valid;
            r_s0.last  <= valid & last;
        end
    end

    always_ff @(posedge aclk) begin
        r_s0_ain <= ain;
    end

    assign w_prod = PROD_W'(w_rdata) * PROD_W'(r_s0_ain);

    always_ff @(posedge aclk) begin
        if (areset) begin
            for (int i = 0; i < PIPE; i++) begin
                r_pv[i] <= '0;
            end
        end else begin
            r_pv[0] <= r_s0;
            for (int i = 1; i < PIPE; i++) begin
                r_pv[i] <= r_pv[i-1];
            end
        end
    end

    always_ff @(posedge aclk) begin
        r_prod[0] <= w_prod;
        for (int i = 1; i < PIPE; i++) begin
            r_prod[i] <= r_prod[i-1];
        end
    end

    assign w_prod_ext = ACC_W'(r_prod[PIPE-1]);

`ifdef MY_PE_SAT_EN
    sat_res_t w_sat;
    logic     r_ovf;

    assign w_sat = sat_add(SAT_MAX_W'(r_acc), SAT_MAX_W'(w_prod_ext), ACC_W);
    assign w_sum = w_sat.sum[ACC_W-1:0];

    always_ff @(posedge aclk) begin
        if (areset) begin
            r_ovf <= 1'b0;
        end else if (r_pv[PIPE-1].valid && w_sat.sat) begin
            r_ovf <= 1'b1;
        end
    end

    assign ovf = r_ovf;
`else
    assign w_sum = r_acc + w_prod_ext;
    assign ovf   = 1'b0;
`endif

    // Accumulate stage: a last element closes the sum and re-arms acc at zero.
    always_ff @(posedge aclk) begin
        if (areset) begin
            r_acc     <= '0;
            r_pending <= 1'b0;
            r_res_vld <= 1'b0;
        end else if (r_pv[PIPE-1].valid) begin
            r_acc     <= r_pv[PIPE-1].last ? '0 : w_sum;
            r_pending <= ~r_pv[PIPE-1].last;
            r_res_vld <= r_pv[PIPE-1].last;
        end else begin
            r_res_vld <= 1'b0;
        end
    end

    always_ff @(posedge aclk) begin
        if (r_pv[PIPE-1].valid && r_pv[PIPE-1].last) begin
            r_res <= w_sum;
        end
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            r_dvalid <= 1'b0;
            r_dout   <= '0;
        end else begin
            r_dvalid <= r_res_vld;
            if (r_res_vld) begin
                r_dout <= r_res;
            end
        end
    end

    // NOTE: default assigned first so the loop cannot infer a latch.
    always_comb begin
        w_busy = r_s0.valid | r_pending | r_res_vld;
        for (int i = 0; i < PIPE; i++) begin
            w_busy = w_busy | r_pv[i].valid;
        end
    end

    assign dvalid = r_dvalid;
    assign dout   = r_dout;
    assign busy   = w_busy;

endmodule

// File: tb/tb_my_pe_vec.sv
// Scoreboard bench for my_pe_vec: a 40-bit and a 32-bit accumulator instance
// share one directed stimulus stream; monitors pop expected results on dvalid.
`timescale 1ns/1ps
module tb_my_pe_vec;

    localparam int DATA_W = 16;
    localparam int ACC_W  = 40;
    localparam int ACC2_W = 32;
    localparam int DEPTH  = 16;
    localparam int PIPE   = 2;
    localparam int ADDR_W = 4;
    localparam int LAT    = PIPE + 3;  // negedge drive -> negedge where dvalid is seen
`ifdef MY_PE_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic              aclk   = 1'b0;
    logic              areset = 1'b1;
    logic              we     = 1'b0;
    logic              valid  = 1'b0;
    logic              last   = 1'b0;
    logic [ADDR_W-1:0] addr   = '0;
    logic [DATA_W-1:0] din    = '0;
    logic [DATA_W-1:0] ain    = '0;

    logic              dvalid1, busy1, ovf1;
    logic [ACC_W-1:0]  dout1;
    logic              dvalid2, busy2, ovf2;
    logic [ACC2_W-1:0] dout2;

    my_pe_vec #(
        .DATA_W (DATA_W),
        .ACC_W  (ACC_W),
        .DEPTH  (DEPTH),
        .PIPE   (PIPE)
    ) u_dut (
        .aclk   (aclk),
        .areset (areset),
        .we     (we),
        .addr   (addr),
        .din    (din),
        .valid  (valid),
        .ain    (ain),
        .last   (last),
        .dvalid (dvalid1),
        .dout   (dout1),
        .busy   (busy1),
        .ovf    (ovf1)
    );

    my_pe_vec #(
        .DATA_W (DATA_W),
        .ACC_W  (ACC2_W),
        .DEPTH  (DEPTH),
        .PIPE   (PIPE)
    ) u_dut32 (
        .aclk   (aclk),
        .areset (areset),
        .we     (we),
        .addr   (addr),
        .din    (din),
        .valid  (valid),
        .ain    (ain),
        .last   (last),
        .dvalid (dvalid2),
        .dout   (dout2),
        .busy   (busy2),
        .ovf    (ovf2)
    );

    always #5 aclk = ~aclk;

    int cyc = 0;
    always @(posedge aclk) cyc <= cyc + 1;

    typedef struct {
        logic [ACC_W-1:0]  v40;
        logic [ACC2_W-1:0] v32;
        bit                ovf32;
        bit                idle;
        int                cyc;
    } exp_t;

    exp_t q40[$];
    exp_t q32[$];
    int   total = 0;
    int   bad   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    always @(negedge aclk) begin
        exp_t e;
        if (dvalid1) begin
            if (q40.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_dvalid40: got dout=0x%0h expected no result", dout1);
            end else begin
                e = q40.pop_front();
                check("dout40", dout1, e.v40);
                check("latency40", cyc, e.cyc);
                check("ovf40", ovf1, 0);
                if (e.idle) check("busy40_at_result", busy1, 0);
            end
        end
    end

    always @(negedge aclk) begin
        exp_t e;
        if (dvalid2) begin
            if (q32.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_dvalid32: got dout=0x%0h expected no result", dout2);
            end else begin
                e = q32.pop_front();
                check("dout32", dout2, e.v32);
                check("latency32", cyc, e.cyc);
                check("ovf32", ovf2, e.ovf32);
                if (e.idle) check("busy32_at_result", busy2, 0);
            end
        end
    end

    task automatic wr(input int a, input int d);
        @(negedge aclk);
        we    = 1'b1;
        addr  = a[ADDR_W-1:0];
        din   = d[DATA_W-1:0];
        valid = 1'b0;
        last  = 1'b0;
    endtask

    task automatic elem(input int a, input int x, input bit lst, input longint r40 = 0,
                        input longint r32 = 0, input bit o32 = 0, input bit idle = 0,
                        input bit w = 0, input int d = 0);
        exp_t e;
        @(negedge aclk);
        addr  = a[ADDR_W-1:0];
        ain   = x[DATA_W-1:0];
        valid = 1'b1;
        last  = lst;
        we    = w;
        din   = d[DATA_W-1:0];
        if (lst) begin
            e.v40   = r40[ACC_W-1:0];
            e.v32   = r32[ACC2_W-1:0];
            e.ovf32 = o32;
            e.idle  = idle;
            e.cyc   = cyc + LAT;
            q40.push_back(e);
            q32.push_back(e);
        end
    endtask

    task automatic idle_cyc(input int n, input bit lst = 0);
        repeat (n) begin
            @(negedge aclk);
            valid = 1'b0;
            last  = lst;
            we    = 1'b0;
        end
    endtask

    task automatic drain();
        int k = 0;
        while ((q40.size() != 0 || q32.size() != 0) && k < 100) begin
            @(negedge aclk);
            k++;
        end
        if (q40.size() != 0 || q32.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain_timeout: got %0d/%0d results outstanding expected 0",
                     q40.size(), q32.size());
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no end of test expected completion");
        $fatal(1);
    end

    initial begin
        repeat (3) @(negedge aclk);
        check("rst_dvalid", dvalid1, 0);
        check("rst_dout", dout1, 0);
        check("rst_busy", busy1, 0);
        check("rst_ovf", ovf1, 0);
        check("rst_dout32", dout2, 0);
        check("rst_ovf32", ovf2, 0);
        areset = 1'b0;

        for (int i = 0; i < DEPTH; i++) wr(i, i + 1);
        idle_cyc(1);

        // Full vector: sum(i+1)*2 over 16 entries = 272
        for (int i = 0; i < DEPTH; i++) elem(i, 2, i == DEPTH - 1, 272, 272, 0, 1);
        idle_cyc(1);
        check("busy_in_flight", busy1, 1);
        drain();

        // Back-to-back: A = 1+2+3+4, B = -(5+6) with a gap carrying a stray last
        elem(0, 1, 0);
        elem(1, 1, 0);
        elem(2, 1, 0);
        elem(3, 1, 1, 10, 10);
        elem(4, -1, 0);
        idle_cyc(1, 1);
        check("busy_in_gap", busy1, 1);
        elem(5, -1, 1, -11, -11, 0, 1);
        idle_cyc(1);
        drain();
        check("busy_after_b2b", busy1, 0);

        // Single-element vector
        wr(7, 8);
        elem(7, 3, 1, 24, 24, 0, 1);
        idle_cyc(1);
        drain();

        // Collision: same-cycle write returns the old word, the next read the new one
        wr(2, 3);
        elem(2, 1, 1, 3, 3, 0, 0, 1, 100);
        elem(2, 1, 1, 100, 100, 0, 1);
        idle_cyc(1);
        drain();

        // Reset mid-vector: partial sum and in-flight elements vanish
        elem(0, 5, 0);
        elem(1, 5, 0);
        @(negedge aclk);
        areset = 1'b1;
        valid  = 1'b0;
        last   = 1'b0;
        we     = 1'b0;
        repeat (2) @(negedge aclk);
        check("midrst_dvalid", dvalid1, 0);
        check("midrst_dout", dout1, 0);
        check("midrst_busy", busy1, 0);
        check("midrst_ovf", ovf1, 0);
        check("midrst_dout32", dout2, 0);
        check("midrst_busy32", busy2, 0);
        areset = 1'b0;
        idle_cyc(8);
        elem(0, 1, 0);
        elem(1, 1, 1, 3, 3, 0, 1);
        idle_cyc(1);
        drain();

        // Overflow: three products of 2^30 in a 32-bit accumulator
        wr(0, -32768);
        elem(0, -32768, 0);
        elem(0, -32768, 0);
        elem(0, -32768, 1, 64'd3221225472, SAT ? 64'h7FFF_FFFF : 64'hC000_0000, SAT, 1);
        idle_cyc(1);
        drain();
        idle_cyc(3);
        check("ovf32_sticky", ovf2, SAT);
        check("ovf40_clear", ovf1, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/my_pe_vec.md
# my_pe_vec

Parametrised successor to the single-lane PE: a local coefficient buffer of DEPTH words plus a pipelined signed fixed-point multiply-accumulate that computes dot products of arbitrary length. Vectors are framed by a `last` flag. The block emits one result per vector with a single-cycle `dvalid` pulse. It sits between the host write path, which loads the coefficient buffer, and the streaming operand source, which drives `ain`/`addr`/`valid`.

## Interface
Parameters:
- DATA_W, 16: width of `din`, `ain` and buffer words (signed).
- ACC_W, 40: accumulator and `dout` width. Must be ≥ 2*DATA_W; elaboration error otherwise.
- DEPTH, 16: buffer entries. ADDR_W = clog2(DEPTH).
- PIPE, 2: multiplier register stages, ≥ 1.

Ports:
- aclk  in  1  sole clock, rising edge.
- areset  in  1  synchronous, active-high reset.
- we  in  1  buffer write enable.
- addr  in  ADDR_W  buffer address, shared by write and compute.
- din  in  DATA_W  buffer write data.
- valid  in  1  operand valid; consumes `ain` and buffer[addr].
- ain  in  DATA_W  streaming operand.
- last  in  1  qualifies `valid`; marks the final element of a vector.
- dvalid  out  1  one-cycle result strobe.
- dout  out  ACC_W  dot-product result, held until the next result.
- busy  out  1  any pipeline stage valid, or a partial sum pending.
- ovf  out  1  sticky saturation flag (see Configuration).

## Operation
- Write: on `we`, buffer[addr] <= din. The buffer is not cleared by reset.
- Compute pipeline:
  - S0: synchronous buffer read of addr; register `ain`, `valid`, `last`.
  - S1..S(PIPE): signed DATA_W×DATA_W product, registered PIPE times.
  - Accumulate stage: product sign-extended to ACC_W, then acc + prod.
    - Not last: acc <= sum.
    - Last: dout <= sum, dvalid <= 1, acc <= 0.
- `valid` may drop between elements; gaps do not disturb the partial sum.
- Back-to-back vectors are allowed: an element following a `last` element starts a fresh sum with no bubble.
- A single-element vector (valid & last) is legal.
- `we` and `valid` in the same cycle at the same addr: the read returns the old word (read-before-write).
- Arithmetic wraps modulo 2^ACC_W unless saturation is compiled in.
- `last` without `valid` is ignored.

## Timing
- Reset values: dvalid=0, dout=0, busy=0, ovf=0, acc=0, all pipeline valid bits 0.
- Latency: valid & last sampled at edge t gives dvalid=1 after edge t+PIPE+2 (t+4 at default settings).
- Throughput: one element per cycle. There is no back-pressure.
- `busy` rises the cycle after the first `valid` and falls the cycle dvalid is asserted if nothing else is in flight.
- Reset mid-vector: the in-flight elements and partial sum are discarded; no dvalid is produced for that vector.

## Configuration
- MY_PE_SAT_EN defined:
  - Each accumulate step saturates to the signed ACC_W max/min.
  - `ovf` sets on any saturation event and clears only on reset.
- MY_PE_SAT_EN undefined:
  - Accumulate wraps.
  - `ovf` is tied to 0.

## Structure
- Package my_pe_pkg:
  - default parameter constants;
  - `sat_add` function (ACC_W-generic via parameterised width);
  - pipeline-stage struct {valid, last}.
- Sub-module my_pe_buf: DEPTH×DATA_W simple dual-port RAM with synchronous read, read-before-write; inferable as BRAM/LUTRAM.
- Top level holds the S0/product pipeline, accumulator, busy logic and result register.

## Test plan
- Reset: areset held 2 cycles mid-stream -> dvalid=0, dout=0, busy=0, ovf=0. No stale result follows.
- Full vector: buf[i]=i+1 for i=0..15; stream ain=2, addr 0..15, last on 15 -> exactly one dvalid at last+4, dout=272.
- Back-to-back vectors with a gap:
  - Vector A: addr 0..3, ain=1, last on 3.
  - Vector B starts the next cycle: addr 4..5, ain=-1, with one idle cycle between its elements.
  - Required: dout=10, then dout=-11; two separate pulses; busy low afterward.
- Single element: buf[7]=8, valid & last, ain=3 -> dout=24 at +4.
- Collision: buf[2]=3; same cycle we addr2 din=100 and valid addr2 ain=1 last -> dout=3. A repeat of the read gives dout=100.
- Overflow: ACC_W=32, buf[0]=-32768, three elements with ain=-32768 (each product 2^30).
  - With MY_PE_SAT_EN: dout=0x7FFFFFFF, ovf=1.
  - Without MY_PE_SAT_EN: dout=0xC0000000, ovf=0.
